// File: rtl/slot_display_pkg.sv
// slot_display_pkg: shared types and constants for the slot machine display back-end
//   state_e        converter FSM states
//   VALUE_W        binary input width, NUM_DIGITS display digits, BCD_W packed BCD width
//   SEG_*          active-low {g,f,e,d,c,b,a} patterns
//   bcd_add3       add-3 correction applied before each shift of the converter
package slot_display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int unsigned VALUE_W    = 11;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
        for (int i = 0; i < NUM_DIGITS; i++)
            bcd_add3[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low seven-segment pattern
//   digit_i  4-bit digit (values above 9 render blank)
//   blank_i  force all segments off
//   seg_o    {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import slot_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: binary to BCD converter plus 4-digit multiplexed seven-segment scanner
//   gameClk            system clock
//   rst_n              asynchronous active-low reset
//   number_to_display  11-bit unsigned value
//   seg                active-low segments {g,f,e,d,c,b,a}
//   an                 active-low one-hot digit enables, an[0] = ones
//   conv_done          one-cycle pulse while new digits are being committed
// Build option: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (ones digit always shown).
module seg7_display_driver
    import slot_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic               gameClk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] number_to_display,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               conv_done
);

    localparam logic [15:0] REF_MAX = 16'(REFRESH_DIV - 1);

    state_e             state_q;
    logic [VALUE_W-1:0] bin_q, last_q;
    logic [BCD_W-1:0]   bcd_q, digits_q, bcd_adj;
    logic [3:0]         cnt_q;
    logic               init_q, conv_done_q, scan_en_q;
    logic [15:0]        refresh_q, refresh_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         digit;
    logic               blank, wrap;

    assign bcd_adj = bcd_add3(bcd_q);

    // The binary register rotates instead of shifting in zeros, so after the
    // last shift it again holds the captured value and doubles as last_value.
    always_ff @(posedge gameClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            init_q      <= 1'b1;
            digits_q    <= '0;
            conv_done_q <= 1'b0;
            scan_en_q   <= 1'b0;
        end else begin
            conv_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (number_to_display != last_q || init_q) begin
                        bin_q   <= number_to_display;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
                    bin_q <= {bin_q[VALUE_W-2:0], bin_q[VALUE_W-1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == 4'(VALUE_W - 1)) begin
                        state_q     <= DONE;
                        conv_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    digits_q  <= bcd_q;
                    last_q    <= bin_q;
                    init_q    <= 1'b0;
                    scan_en_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wrap      = refresh_q == REF_MAX;
        refresh_d = wrap ? '0 : refresh_q + 1'b1;
        idx_d     = wrap ? idx_q + 1'b1 : idx_q;
        digit     = digits_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank     = idx_q != 2'd0 && (digits_q >> {idx_q, 2'b00}) == '0;
`else
        blank     = 1'b0;
`endif
    end

    seg7_decode u_decode (
        .digit_i (digit),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    // Scanning stays frozen (all digits off) until the first commit.
    always_ff @(posedge gameClk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else if (scan_en_q) begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= ~(4'b0001 << idx_q);
            seg_q     <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign conv_done = conv_done_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: randomized and directed checks against a behavioural display model
module tb_seg7_display_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] din = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        conv_done;

    int nvec = 0;
    int nerr = 0;

    seg7_display_driver #(.REFRESH_DIV(DIV)) dut (
        .gameClk           (clk),
        .rst_n             (rst_n),
        .number_to_display (din),
        .seg               (seg),
        .an                (an),
        .conv_done         (conv_done)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic int pow10(input int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i);
        logic blk = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blk = i > 0 && v < pow10(i);
`endif
        return blk ? 7'b1111111 : pat[(v / pow10(i)) % 10];
    endfunction

    function automatic int slot(input int k);
        return (k / DIV) % 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Behavioural model: a conversion is a 12-cycle busy window started from idle
    // when the input differs from the last committed value; the scanner walks
    // digits at DIV cycles per slot starting the cycle after the commit.
    int          m_cd, m_k;
    logic        m_init, m_scan, e_done;
    int          m_last, m_cap, m_val;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cd <= 0; m_k <= 0; m_init <= 1'b1; m_scan <= 1'b0; e_done <= 1'b0;
            m_last <= 0; m_cap <= 0; m_val <= 0; e_an <= 4'hF; e_seg <= 7'h7F;
        end else begin
            if (m_cd == 0) begin
                if (int'(din) != m_last || m_init) begin
                    m_cap <= int'(din);
                    m_cd  <= 12;
                end
            end else
                m_cd <= m_cd - 1;
            e_done <= m_cd == 2;
            if (m_cd == 1) begin
                m_val <= m_cap; m_last <= m_cap; m_init <= 1'b0; m_scan <= 1'b1;
            end
            if (m_scan) begin
                m_k   <= m_k + 1;
                e_an  <= ~(4'b0001 << slot(m_k));
                e_seg <= exp_seg(m_val, slot(m_k));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("conv_done", conv_done, e_done);
        end
    end

    task automatic wait_done(input int lim);
        int n = 0;
        do begin @(negedge clk); n++; end while (!conv_done && n < lim);
        chk("done_timeout", conv_done, 1);
    endtask

    task automatic release_and_count(input string nm);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            chk(nm, conv_done, i == 12);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, run, v;
        logic [3:0] prev, seen;
        logic first;
        // reset behaviour and first conversion of 0
        repeat (3) @(posedge clk); #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_done", conv_done, 0);
        release_and_count("done_cycle_after_rst");
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 7'b1000000);
        repeat (4) @(posedge clk); #1;
        chk("second_an", an, 4'b1101);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk("second_seg", seg, 7'b1111111);
`else
        chk("second_seg", seg, 7'b1000000);
`endif
        // maximum value
        @(negedge clk) din = 11'd2047;
        wait_done(40);
        repeat (2) @(posedge clk);
        seen = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            seen |= ~an;
            case (an)
                4'b1110: chk("d2047_ones", seg, 7'b1111000);
                4'b1101: chk("d2047_tens", seg, 7'b0011001);
                4'b1011: chk("d2047_hund", seg, 7'b1000000);
                4'b0111: chk("d2047_thou", seg, 7'b0100100);
                default: chk("d2047_an_onehot", an, 4'b1110);
            endcase
        end
        chk("d2047_all_slots", seen, 4'hF);
        // change arriving mid-conversion
        @(negedge clk) din = 11'd100;
        pulses = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 6) din = 11'd999;
            if (conv_done) pulses++;
        end
        chk("two_pulses", pulses, 2);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (an == 4'b1110) chk("d999_ones", seg, 7'b0010000);
        end
        // scan rotation and hold time
        first = 1'b1; run = 0;
        @(negedge clk) prev = an;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            run++;
            if (an != prev) begin
                if (!first) chk("hold_len", run, DIV);
                chk("rotate", an, {prev[2:0], prev[3]});
                first = 1'b0; run = 0; prev = an;
            end
        end
        // asynchronous reset mid-conversion
        @(negedge clk) din = 11'd1234;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_seg", seg, 7'h7F);
        chk("async_done", conv_done, 0);
        @(posedge clk);
        release_and_count("done_cycle_after_async");
        chk("d1234_an", an, 4'b1110);
        chk("d1234_ones", seg, 7'b0011001);
        // steady input: no further conversions
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (conv_done) pulses++;
        end
        chk("no_reconvert", pulses, 0);
        // random traffic, checked every cycle by the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                v = $urandom_range(0, 9);
                din = v == 0 ? 11'd0 : v == 1 ? 11'd2047 : 11'($urandom_range(0, 2047));
            end
        end
        repeat (60) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
